reg_share_arbiter: RTL and testbench

//   Round-robin arbiter that shares one DATA_W-bit synchronous-reset storage register between NUM_REQ requesters.

---
 rtl/reg_share_pkg.sv | 19 +
 rtl/reg_share_arbiter_rr_pick.sv | 44 ++++
 rtl/reg_share_arbiter.sv | 110 +++++++++++
 tb/tb_reg_share_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/reg_share_pkg.sv
// Shared definitions for the register-sharing arbiter: FSM state encodings
// and a constant-evaluable ceil(log2) helper used to size index ports.
package reg_share_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first asserted request
// starting at ptr and wrapping explicitly so no index ever reaches NUM_REQ.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2_f(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   sel
);

  // Priority search over the rotated request vector.
  always_comb begin
    int base;
    int idx;
    logic found;
    found = 1'b0;
    sel   = '0;
    if (int'(ptr) >= NUM_REQ) begin
      base = 0;
    end else begin
      base = int'(ptr);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = base + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end else begin
        found = found;
      end
    end
    any = found;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter owning one shared storage register; grants one writer,
// pulses ack for a cycle, then holds q stable for HOLD_CYCLES before re-arbitrating.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_W-1:0]     wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_W-1:0]             q,
  output logic [clog2_f(NUM_REQ)-1:0]   owner,
  output logic                          valid,
  output logic                          busy
);

  localparam int IDX_W = clog2_f(NUM_REQ);
  localparam int CNT_W = (clog2_f(HOLD_CYCLES + 1) < 1) ? 1 : clog2_f(HOLD_CYCLES + 1);

  state_e               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [CNT_W-1:0]     hold_cnt_q;
  logic [DATA_W-1:0]    data_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [NUM_REQ-1:0]   ack_d;
  logic [IDX_W-1:0]     owner_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 pick_any;
  logic [IDX_W-1:0]     pick_sel;
  logic [DATA_W-1:0]    lane_d;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .sel (pick_sel)
  );

  // Winner's lane, one-hot ack and the wrapped next pointer.
  always_comb begin
    lane_d = wdata[int'(pick_sel)*DATA_W +: DATA_W];
    ack_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_sel;
    if (int'(pick_sel) == NUM_REQ - 1) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = pick_sel + IDX_W'(1);
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      owner_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            data_q     <= lane_d;
            owner_q    <= pick_sel;
            valid_q    <= 1'b1;
            ack_q      <= ack_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= CNT_W'(HOLD_CYCLES - 1);
            busy_q     <= 1'b1;
            state_q    <= ST_HOLD;
          end else begin
            ack_q <= '0;
          end
        end
        ST_HOLD: begin
          ack_q <= '0;
          if (hold_cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack   = ack_q;
  assign q     = data_q;
  assign owner = owner_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: a vector table for the grant sequences
// plus hand-written sequences for mid-hold reset and wdata changes during HOLD.
module tb_reg_share_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        valid;
  logic        busy;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] wd;
    logic [3:0]  e_ack;
    logic [7:0]  e_q;
    logic [1:0]  e_own;
    logic        e_valid;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  reg_share_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .HOLD_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                     input logic [3:0] a, input logic [7:0] qq, input logic [1:0] o,
                     input logic v, input logic b);
    vec_t t;
    t.rst = r; t.rq = rq; t.wd = wd; t.e_ack = a;
    t.e_q = qq; t.e_own = o; t.e_valid = v; t.e_busy = b;
    vq.push_back(t);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] a, input logic [7:0] qq,
                         input logic [1:0] o, input logic v, input logic b);
    chk({tag, ".ack"},   32'(ack),   32'(a));
    chk({tag, ".q"},     32'(q),     32'(qq));
    chk({tag, ".owner"}, 32'(owner), 32'(o));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  localparam logic [31:0] LANES = 32'h44332211;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    req   = 4'b0000;
    wdata = 32'h0000_0000;

    // reset with all requests raised
    add(1'b1, 4'b1111, LANES,        4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, LANES,        4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    // single request on lane 2
    add(1'b0, 4'b0100, 32'h00380000, 4'b0100, 8'h38, 2'd2, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 32'h00380000, 4'b0000, 8'h38, 2'd2, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 32'h00380000, 4'b0000, 8'h38, 2'd2, 1'b1, 1'b0);
    // reset to bring rr_ptr back to 0
    add(1'b1, 4'b0000, LANES,        4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    // all four requesting, each drops after its ack
    add(1'b0, 4'b1111, LANES,        4'b0001, 8'h11, 2'd0, 1'b1, 1'b1);
    add(1'b0, 4'b1110, LANES,        4'b0000, 8'h11, 2'd0, 1'b1, 1'b1);
    add(1'b0, 4'b1110, LANES,        4'b0000, 8'h11, 2'd0, 1'b1, 1'b0);
    add(1'b0, 4'b1110, LANES,        4'b0010, 8'h22, 2'd1, 1'b1, 1'b1);
    add(1'b0, 4'b1100, LANES,        4'b0000, 8'h22, 2'd1, 1'b1, 1'b1);
    add(1'b0, 4'b1100, LANES,        4'b0000, 8'h22, 2'd1, 1'b1, 1'b0);
    add(1'b0, 4'b1100, LANES,        4'b0100, 8'h33, 2'd2, 1'b1, 1'b1);
    add(1'b0, 4'b1000, LANES,        4'b0000, 8'h33, 2'd2, 1'b1, 1'b1);
    add(1'b0, 4'b1000, LANES,        4'b0000, 8'h33, 2'd2, 1'b1, 1'b0);
    add(1'b0, 4'b1000, LANES,        4'b1000, 8'h44, 2'd3, 1'b1, 1'b1);
    add(1'b0, 4'b0000, LANES,        4'b0000, 8'h44, 2'd3, 1'b1, 1'b1);
    add(1'b0, 4'b0000, LANES,        4'b0000, 8'h44, 2'd3, 1'b1, 1'b0);
    // rr_ptr wrapped to 0: grant 1, then 0011 must wrap search 2,3,0
    add(1'b0, 4'b0010, LANES,        4'b0010, 8'h22, 2'd1, 1'b1, 1'b1);
    add(1'b0, 4'b0011, LANES,        4'b0000, 8'h22, 2'd1, 1'b1, 1'b1);
    add(1'b0, 4'b0011, LANES,        4'b0000, 8'h22, 2'd1, 1'b1, 1'b0);
    add(1'b0, 4'b0011, LANES,        4'b0001, 8'h11, 2'd0, 1'b1, 1'b1);
    add(1'b0, 4'b0010, LANES,        4'b0000, 8'h11, 2'd0, 1'b1, 1'b1);
    add(1'b0, 4'b0010, LANES,        4'b0000, 8'h11, 2'd0, 1'b1, 1'b0);
    add(1'b0, 4'b0010, LANES,        4'b0010, 8'h22, 2'd1, 1'b1, 1'b1);
    add(1'b0, 4'b0000, LANES,        4'b0000, 8'h22, 2'd1, 1'b1, 1'b1);
    add(1'b0, 4'b0000, LANES,        4'b0000, 8'h22, 2'd1, 1'b1, 1'b0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst;
      req   = vq[i].rq;
      wdata = vq[i].wd;
      tick();
      chk_all($sformatf("v%0d", i), vq[i].e_ack, vq[i].e_q, vq[i].e_own,
              vq[i].e_valid, vq[i].e_busy);
    end

    // mid-HOLD synchronous reset: q must not move until the edge
    reset = 1'b0;
    req   = 4'b0100;
    wdata = 32'h00380000;
    tick();
    chk_all("mr.load", 4'b0100, 8'h38, 2'd2, 1'b1, 1'b1);
    req = 4'b0000;
    #9;
    reset = 1'b1;
    #10;
    chk("mr.q_before_edge", 32'(q), 32'h38);
    chk("mr.busy_before_edge", 32'(busy), 32'h1);
    tick();
    chk_all("mr.after", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
    // rr_ptr also reset: full request set goes to requester 0
    reset = 1'b0;
    req   = 4'b1111;
    wdata = LANES;
    tick();
    chk_all("mr.ptr", 4'b0001, 8'h11, 2'd0, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    tick();
    chk("mr.idle_busy", 32'(busy), 32'h0);

    // lane 0 data changes during HOLD must not reach q until the next IDLE grant
    req   = 4'b0001;
    wdata = 32'h5566_77AA;
    tick();
    chk_all("hd.load", 4'b0001, 8'hAA, 2'd0, 1'b1, 1'b1);
    wdata = 32'h0000_00F0;
    tick();
    chk_all("hd.hold1", 4'b0000, 8'hAA, 2'd0, 1'b1, 1'b1);
    tick();
    chk_all("hd.hold2", 4'b0000, 8'hAA, 2'd0, 1'b1, 1'b0);
    tick();
    chk_all("hd.reload", 4'b0001, 8'hF0, 2'd0, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    chk("hd.ack_clear", 32'(ack), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
